// File: rtl/connect_four_judge.sv
// Connect-Four win/draw judge: shadows the board, scans four line directions through each new piece.
// Result 25 edges after acceptance (WIN_LEN=4); moves arriving while busy are rejected with move_err.
module connect_four_judge #(
    parameter int ROWS    = 6,
    parameter int COLS    = 7,
    parameter int WIN_LEN = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clear,
    input  logic       move_valid,
    input  logic [2:0] move_row,
    input  logic [2:0] move_col,
    input  logic [1:0] move_player,
    output logic       busy,
    output logic       result_valid,
    output logic [1:0] winner,
    output logic       game_over,
    output logic       move_err
);

    typedef enum logic [1:0] {IDLE = 2'd0, SCAN = 2'd1, DONE = 2'd2} state_t;

    localparam logic [2:0]        ROWS_U    = 3'(ROWS);
    localparam logic [2:0]        COLS_U    = 3'(COLS);
    localparam logic signed [5:0] ROWS_S    = 6'(ROWS);
    localparam logic signed [5:0] COLS_S    = 6'(COLS);
    localparam logic [1:0]        LAST_STEP = 2'(WIN_LEN - 1);
    localparam logic [3:0]        WIN_LEN_U = 4'(WIN_LEN);
    localparam logic [5:0]        CELLS     = 6'(ROWS * COLS);

    state_t                 state_q, state_d;
    logic [7:0][7:0][1:0]   board_q, board_d;
    logic [5:0]             cnt_q, cnt_d;
    logic [2:0]             org_row_q, org_row_d, org_col_q, org_col_d;
    logic [1:0]             player_q, player_d;
    logic [1:0]             dir_q, dir_d;
    logic                   half_q, half_d;
    logic [1:0]             step_q, step_d;
    logic [2:0]             tally_q, tally_d;
    logic                   run_q, run_d, win_q, win_d;
    logic                   busy_q, busy_d, result_valid_q, result_valid_d;
    logic [1:0]             winner_q, winner_d;
    logic                   game_over_q, game_over_d, move_err_q, move_err_d;

    logic signed [5:0]      dr, dc, cr, cc;
    logic                   in_bounds, hit, move_ok;
    logic [2:0]             tally_n;

    // Address of the cell under examination: origin + step * direction (negated on the second half).
    always_comb begin
        dr = (dir_q == 2'd0) ? 6'sd0 : 6'sd1;
        case (dir_q)
            2'd0:    dc = 6'sd1;
            2'd1:    dc = 6'sd0;
            2'd2:    dc = 6'sd1;
            default: dc = -6'sd1;
        endcase
        if (half_q) begin
            dr = -dr;
            dc = -dc;
        end
        cr = $signed({3'b000, org_row_q}) + dr * $signed({4'b0000, step_q});
        cc = $signed({3'b000, org_col_q}) + dc * $signed({4'b0000, step_q});
        in_bounds = (cr >= 6'sd1) && (cr <= ROWS_S) && (cc >= 6'sd1) && (cc <= COLS_S);
        hit = run_q && in_bounds && (board_q[cr[2:0]][cc[2:0]] == player_q);
        tally_n = tally_q + {2'b00, hit};
    end

    always_comb begin
        state_d        = state_q;
        board_d        = board_q;
        cnt_d          = cnt_q;
        org_row_d      = org_row_q;
        org_col_d      = org_col_q;
        player_d       = player_q;
        dir_d          = dir_q;
        half_d         = half_q;
        step_d         = step_q;
        tally_d        = tally_q;
        run_d          = run_q;
        win_d          = win_q;
        busy_d         = busy_q;
        result_valid_d = 1'b0;
        winner_d       = winner_q;
        game_over_d    = game_over_q;
        move_err_d     = 1'b0;

        move_ok = !game_over_q
               && (move_row != 3'd0) && (move_row <= ROWS_U)
               && (move_col != 3'd0) && (move_col <= COLS_U)
               && ((move_player == 2'b01) || (move_player == 2'b10))
               && (board_q[move_row][move_col] == 2'b00);

        if (clear) begin
            board_d     = '0;
            cnt_d       = '0;
            winner_d    = 2'b00;
            game_over_d = 1'b0;
            busy_d      = 1'b0;
            state_d     = IDLE;
        end else begin
            if (move_valid && !((state_q == IDLE) && move_ok))
                move_err_d = 1'b1;
            case (state_q)
                IDLE: begin
                    if (move_valid && move_ok) begin
                        board_d[move_row][move_col] = move_player;
                        cnt_d     = cnt_q + 6'd1;
                        org_row_d = move_row;
                        org_col_d = move_col;
                        player_d  = move_player;
                        dir_d     = 2'd0;
                        half_d    = 1'b0;
                        step_d    = 2'd1;
                        tally_d   = 3'd0;
                        run_d     = 1'b1;
                        win_d     = 1'b0;
                        busy_d    = 1'b1;
                        state_d   = SCAN;
                    end
                end
                SCAN: begin
                    if (step_q != LAST_STEP) begin
                        step_d  = step_q + 2'd1;
                        tally_d = tally_n;
                        run_d   = hit;
                    end else if (!half_q) begin
                        half_d  = 1'b1;
                        step_d  = 2'd1;
                        tally_d = tally_n;
                        run_d   = 1'b1;
                    end else begin
                        // End of a direction: judge it, then start the next one afresh.
                        if (({1'b0, tally_n} + 4'd1) >= WIN_LEN_U)
                            win_d = 1'b1;
                        half_d  = 1'b0;
                        step_d  = 2'd1;
                        tally_d = 3'd0;
                        run_d   = 1'b1;
                        dir_d   = dir_q + 2'd1;
                        if (dir_q == 2'd3)
                            state_d = DONE;
                    end
                end
                DONE: begin
                    result_valid_d = 1'b1;
                    busy_d         = 1'b0;
                    if (win_q) begin
                        winner_d    = player_q;
                        game_over_d = 1'b1;
                    end else if (cnt_q == CELLS) begin
                        winner_d    = 2'b11;
                        game_over_d = 1'b1;
                    end else begin
                        winner_d    = 2'b00;
                    end
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= IDLE;
            board_q        <= '0;
            cnt_q          <= '0;
            org_row_q      <= '0;
            org_col_q      <= '0;
            player_q       <= '0;
            dir_q          <= '0;
            half_q         <= 1'b0;
            step_q         <= 2'd1;
            tally_q        <= '0;
            run_q          <= 1'b0;
            win_q          <= 1'b0;
            busy_q         <= 1'b0;
            result_valid_q <= 1'b0;
            winner_q       <= 2'b00;
            game_over_q    <= 1'b0;
            move_err_q     <= 1'b0;
        end else begin
            state_q        <= state_d;
            board_q        <= board_d;
            cnt_q          <= cnt_d;
            org_row_q      <= org_row_d;
            org_col_q      <= org_col_d;
            player_q       <= player_d;
            dir_q          <= dir_d;
            half_q         <= half_d;
            step_q         <= step_d;
            tally_q        <= tally_d;
            run_q          <= run_d;
            win_q          <= win_d;
            busy_q         <= busy_d;
            result_valid_q <= result_valid_d;
            winner_q       <= winner_d;
            game_over_q    <= game_over_d;
            move_err_q     <= move_err_d;
        end
    end

    assign busy         = busy_q;
    assign result_valid = result_valid_q;
    assign winner       = winner_q;
    assign game_over    = game_over_q;
    assign move_err     = move_err_q;

endmodule

// File: tb/tb_connect_four_judge.sv
// Self-checking bench for connect_four_judge: move table, scoreboard of expected results, abort sequences.
module tb_connect_four_judge;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       clear = 1'b0;
    logic       move_valid = 1'b0;
    logic [2:0] move_row = '0;
    logic [2:0] move_col = '0;
    logic [1:0] move_player = '0;
    logic       busy, result_valid, game_over, move_err;
    logic [1:0] winner;

    int total = 0;
    int bad   = 0;
    logic [2:0] sb_q[$];
    logic [1:0] mb[8][8];

    typedef struct {
        logic       clr;
        logic [2:0] r;
        logic [2:0] c;
        logic [1:0] p;
        logic       e_err;
        logic [1:0] e_win;
        logic       e_over;
    } vec_t;
    vec_t tbl[20];

    connect_four_judge dut (
        .clk(clk), .rst(rst), .clear(clear), .move_valid(move_valid),
        .move_row(move_row), .move_col(move_col), .move_player(move_player),
        .busy(busy), .result_valid(result_valid), .winner(winner),
        .game_over(game_over), .move_err(move_err)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic clear_game();
        @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++)
                mb[r][c] = 2'b00;
    endtask

    task automatic drive(input logic [2:0] r, input logic [2:0] c, input logic [1:0] p);
        @(negedge clk);
        move_valid  = 1'b1;
        move_row    = r;
        move_col    = c;
        move_player = p;
        @(negedge clk);
        move_valid  = 1'b0;
    endtask

    // Called at a negedge after edge E<start>; waits for the result pulse and scores it.
    task automatic wait_result(input string tag, input int start);
        int lat;
        logic [2:0] e;
        lat = start;
        do begin
            @(negedge clk);
            lat++;
        end while (!result_valid && lat < 40);
        chk({tag, " latency"}, lat, 25);
        if (sb_q.size() == 0) begin
            chk({tag, " scoreboard_empty"}, 1, 0);
        end else begin
            e = sb_q.pop_front();
            chk({tag, " winner"}, int'(winner), int'(e[2:1]));
            chk({tag, " game_over"}, int'(game_over), int'(e[0]));
        end
        @(negedge clk);
        chk({tag, " rv_one_cycle"}, int'(result_valid), 0);
        chk({tag, " busy_low"}, int'(busy), 0);
    endtask

    task automatic play(input logic [2:0] r, input logic [2:0] c, input logic [1:0] p,
                        input logic e_err, input logic [1:0] e_win, input logic e_over,
                        input string tag);
        int seen;
        if (!e_err) sb_q.push_back({e_win, e_over});
        drive(r, c, p);
        chk({tag, " move_err"}, int'(move_err), int'(e_err));
        if (e_err) begin
            seen = 0;
            repeat (30) begin
                if (result_valid) seen = 1;
                @(negedge clk);
            end
            chk({tag, " no_result"}, seen, 0);
        end else begin
            chk({tag, " busy_high"}, int'(busy), 1);
            wait_result(tag, 0);
        end
    endtask

    function automatic bit has_line(input logic [1:0] p);
        int dr[4] = '{0, 1, 1, 1};
        int dc[4] = '{1, 0, 1, -1};
        for (int r = 1; r <= 6; r++)
            for (int c = 1; c <= 7; c++)
                for (int d = 0; d < 4; d++) begin
                    int k;
                    for (k = 0; k < 4; k++) begin
                        int rr = r + k * dr[d];
                        int cc = c + k * dc[d];
                        if (rr < 1 || rr > 6 || cc < 1 || cc > 7) break;
                        if (mb[rr][cc] != p) break;
                    end
                    if (k == 4) return 1'b1;
                end
        return 1'b0;
    endfunction

    initial begin
        int seen, n;
        logic [1:0] p, ew;

        tbl[0]  = '{1'b0, 3'd1, 3'd1, 2'd1, 1'b0, 2'd0, 1'b0};
        tbl[1]  = '{1'b0, 3'd2, 3'd1, 2'd2, 1'b0, 2'd0, 1'b0};
        tbl[2]  = '{1'b0, 3'd1, 3'd2, 2'd1, 1'b0, 2'd0, 1'b0};
        tbl[3]  = '{1'b0, 3'd2, 3'd2, 2'd2, 1'b0, 2'd0, 1'b0};
        tbl[4]  = '{1'b0, 3'd1, 3'd3, 2'd1, 1'b0, 2'd0, 1'b0};
        tbl[5]  = '{1'b0, 3'd2, 3'd3, 2'd2, 1'b0, 2'd0, 1'b0};
        tbl[6]  = '{1'b0, 3'd1, 3'd4, 2'd1, 1'b0, 2'd1, 1'b1};
        tbl[7]  = '{1'b0, 3'd3, 3'd5, 2'd2, 1'b1, 2'd0, 1'b0};
        tbl[8]  = '{1'b1, 3'd1, 3'd1, 2'd2, 1'b0, 2'd0, 1'b0};
        tbl[9]  = '{1'b0, 3'd1, 3'd2, 2'd1, 1'b0, 2'd0, 1'b0};
        tbl[10] = '{1'b0, 3'd2, 3'd2, 2'd2, 1'b0, 2'd0, 1'b0};
        tbl[11] = '{1'b0, 3'd1, 3'd3, 2'd1, 1'b0, 2'd0, 1'b0};
        tbl[12] = '{1'b0, 3'd4, 3'd4, 2'd2, 1'b0, 2'd0, 1'b0};
        tbl[13] = '{1'b0, 3'd1, 3'd5, 2'd1, 1'b0, 2'd0, 1'b0};
        tbl[14] = '{1'b0, 3'd1, 3'd1, 2'd1, 1'b1, 2'd0, 1'b0};
        tbl[15] = '{1'b0, 3'd7, 3'd1, 2'd1, 1'b1, 2'd0, 1'b0};
        tbl[16] = '{1'b0, 3'd1, 3'd0, 2'd1, 1'b1, 2'd0, 1'b0};
        tbl[17] = '{1'b0, 3'd5, 3'd5, 2'd3, 1'b1, 2'd0, 1'b0};
        tbl[18] = '{1'b0, 3'd3, 3'd3, 2'd2, 1'b0, 2'd2, 1'b1};
        tbl[19] = '{1'b0, 3'd5, 3'd5, 2'd1, 1'b1, 2'd0, 1'b0};

        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        chk("reset busy", int'(busy), 0);
        chk("reset result_valid", int'(result_valid), 0);
        chk("reset winner", int'(winner), 0);
        chk("reset game_over", int'(game_over), 0);
        chk("reset move_err", int'(move_err), 0);

        // Horizontal win, post-game-over rejection, then the diagonal gap-fill game.
        for (int i = 0; i < 20; i++) begin
            if (tbl[i].clr) clear_game();
            play(tbl[i].r, tbl[i].c, tbl[i].p, tbl[i].e_err, tbl[i].e_win, tbl[i].e_over,
                 $sformatf("vec%0d", i));
        end
        chk("winner held after game_over", int'(winner), 2);

        clear_game();
        chk("clear winner", int'(winner), 0);
        chk("clear game_over", int'(game_over), 0);

        // Move strobed at E5 of a scan is refused and does not touch the board.
        sb_q.push_back(3'b000);
        drive(3'd2, 3'd2, 2'd1);
        repeat (4) @(negedge clk);
        move_valid = 1'b1; move_row = 3'd3; move_col = 3'd3; move_player = 2'd2;
        @(negedge clk);
        move_valid = 1'b0;
        chk("midscan move_err", int'(move_err), 1);
        chk("midscan busy", int'(busy), 1);
        wait_result("midscan", 5);
        play(3'd3, 3'd3, 2'd2, 1'b0, 2'd0, 1'b0, "after_midscan");

        // Clear at E10 aborts the scan silently; the cell is free again.
        drive(3'd4, 3'd4, 2'd1);
        repeat (9) @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        chk("abort busy", int'(busy), 0);
        seen = 0;
        repeat (30) begin
            if (result_valid) seen = 1;
            @(negedge clk);
        end
        chk("abort no_result", seen, 0);
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++)
                mb[r][c] = 2'b00;
        play(3'd4, 3'd4, 2'd1, 1'b0, 2'd0, 1'b0, "after_abort");

        // Draw: parity pattern with horizontal runs of two; model confirms no line of four.
        clear_game();
        n = 0;
        for (int r = 1; r <= 6; r++)
            for (int c = 1; c <= 7; c++) begin
                p = ((((c - 1) / 2) + r) % 2 != 0) ? 2'd2 : 2'd1;
                mb[r][c] = p;
                n++;
                ew = has_line(p) ? p : ((n == 42) ? 2'd3 : 2'd0);
                play(3'(r), 3'(c), p, 1'b0, ew, ew != 2'd0, $sformatf("draw_%0d_%0d", r, c));
            end
        play(3'd1, 3'd1, 2'd1, 1'b1, 2'd0, 1'b0, "draw_43rd");
        chk("draw final winner", int'(winner), 3);

        // Asynchronous reset in the middle of a scan.
        clear_game();
        drive(3'd1, 3'd1, 2'd1);
        chk("prerst busy", int'(busy), 1);
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("rst outputs", int'({busy, result_valid, winner, game_over, move_err}), 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (30) @(negedge clk);
        chk("post rst result_valid", int'(result_valid), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
